// File: rtl/knn_vote_select.sv
// K-nearest-neighbour selector: keeps the K smallest distances in a sorted list,
// then counts neighbour types and majority-votes the inferred type.
module knn_vote_select #(
  parameter int unsigned K      = 15,
  parameter int unsigned L      = 128,
  parameter int unsigned DIST_W = 32,
  parameter int unsigned TYPE_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DIST_W-1:0] in_dist,
  input  logic [TYPE_W-1:0] in_type,
  input  logic              in_last,
  output logic              busy,
  output logic              done,
  output logic [TYPE_W-1:0] inferred_type
);

  localparam int unsigned NTypes  = 2 ** TYPE_W;
  localparam int unsigned MaxWalk = (K > NTypes) ? K : NTypes;
  localparam int unsigned IdxW    = $clog2(MaxWalk + 1);
  localparam int unsigned SmpW    = $clog2(L + 1);
  localparam int unsigned VoteW   = $clog2(K + 1);

  localparam logic [IdxW-1:0] LastEntry = IdxW'(K - 1);
  localparam logic [IdxW-1:0] LastBin   = IdxW'(NTypes - 1);
  localparam logic [SmpW-1:0] LastSmp   = SmpW'(L - 1);

  typedef enum logic [2:0] {StIdle, StCollect, StCount, StVote, StDone} state_e;

  state_e              state_q, state_d;
  logic [IdxW-1:0]     idx_q;
  logic [SmpW-1:0]     smp_q;
  logic [DIST_W-1:0]   dist_q [K];
  logic [DIST_W-1:0]   dist_d [K];
  logic [TYPE_W-1:0]   type_q [K];
  logic [TYPE_W-1:0]   type_d [K];
  logic [K-1:0]        valid_q, valid_d;
  logic [K-1:0]        le;
  logic [VoteW-1:0]    vote_q [NTypes];
  logic [VoteW-1:0]    best_cnt_q;
  logic [TYPE_W-1:0]   best_type_q;
  logic [TYPE_W-1:0]   inferred_q;
  logic                done_q;
  logic                accept, last_acc, clear_list;

  assign in_ready      = (state_q == StCollect) && !start;
  assign busy          = (state_q != StIdle);
  assign done          = done_q;
  assign inferred_type = inferred_q;

  assign accept     = in_valid && in_ready;
  assign last_acc   = accept && (in_last || (smp_q == LastSmp));
  assign clear_list = start && ((state_q == StIdle) || (state_q == StCollect));

  // Valid entries form a prefix, so le is a prefix mask and its edge is the insert slot.
  always_comb begin
    le = '0;
    for (int i = 0; i < K; i++) begin
      le[i] = valid_q[i] && (dist_q[i] <= in_dist);
    end
  end

  always_comb begin
    valid_d = valid_q;
    dist_d  = dist_q;
    type_d  = type_q;
    if (clear_list) begin
      valid_d = '0;
    end else if (accept) begin
      for (int i = K - 1; i > 0; i--) begin
        if (!le[i]) begin
          if (le[i-1]) begin
            dist_d[i]  = in_dist;
            type_d[i]  = in_type;
            valid_d[i] = 1'b1;
          end else begin
            dist_d[i]  = dist_q[i-1];
            type_d[i]  = type_q[i-1];
            valid_d[i] = valid_q[i-1];
          end
        end
      end
      if (!le[0]) begin
        dist_d[0]  = in_dist;
        type_d[0]  = in_type;
        valid_d[0] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:    if (start) state_d = StCollect;
      StCollect: if (last_acc) state_d = StCount;
      StCount:   if (idx_q == LastEntry) state_d = StVote;
      StVote:    if (idx_q == LastBin) state_d = StDone;
      StDone:    state_d = StIdle;
      default:   state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      valid_q     <= '0;
      idx_q       <= '0;
      smp_q       <= '0;
      vote_q      <= '{default: '0};
      best_cnt_q  <= '0;
      best_type_q <= '0;
      inferred_q  <= '0;
      done_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      done_q  <= 1'b0;
      if (clear_list) begin
        smp_q <= '0;
      end else if (accept) begin
        smp_q <= smp_q + 1'b1;
      end
      case (state_q)
        StCollect: begin
          if (last_acc) begin
            idx_q  <= '0;
            vote_q <= '{default: '0};
          end
        end
        StCount: begin
          if (valid_q[idx_q]) begin
            vote_q[type_q[idx_q]] <= vote_q[type_q[idx_q]] + 1'b1;
          end
          if (idx_q == LastEntry) begin
            idx_q       <= '0;
            best_cnt_q  <= '0;
            best_type_q <= '0;
          end else begin
            idx_q <= idx_q + 1'b1;
          end
        end
        StVote: begin
          // Strictly greater keeps the lowest type index on a tie.
          if (vote_q[idx_q[TYPE_W-1:0]] > best_cnt_q) begin
            best_cnt_q  <= vote_q[idx_q[TYPE_W-1:0]];
            best_type_q <= idx_q[TYPE_W-1:0];
          end
          idx_q <= idx_q + 1'b1;
        end
        StDone: begin
          inferred_q <= best_type_q;
          done_q     <= 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  // List payload needs no reset; valid_q gates every use of it.
  always_ff @(posedge clk) begin
    dist_q <= dist_d;
    type_q <= type_d;
  end

endmodule

// File: tb/tb_knn_vote_select.sv
// Randomised and directed bench for knn_vote_select, checked against a
// stable-sort-and-count reference model.
module tb_knn_vote_select;

  localparam int K   = 15;
  localparam int L   = 128;
  localparam int NT  = 8;
  localparam int LAT = K + NT + 1;

  logic        clk = 1'b0;
  logic        rst, start, in_valid, in_ready, in_last, busy, done;
  logic [31:0] in_dist;
  logic [2:0]  in_type, inferred_type;

  int checks = 0;
  int passed = 0;

  logic [31:0] stim_dist[$];
  logic [2:0]  stim_type[$];
  logic [31:0] acc_dist[$];
  logic [2:0]  acc_type[$];

  logic [31:0] exp_kd[K];
  logic [2:0]  exp_kt[K];
  int          exp_kn;
  int          exp_type;

  knn_vote_select #(.K(K), .L(L), .DIST_W(32), .TYPE_W(3)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_dist      (in_dist),
    .in_type      (in_type),
    .in_last      (in_last),
    .busy         (busy),
    .done         (done),
    .inferred_type(inferred_type)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Reference: stable selection of the K nearest, then plurality with lowest-index tie-break.
  task automatic run_model();
    int n;
    bit used[L];
    int cnt[NT];
    n = acc_dist.size();
    for (int j = 0; j < L; j++) used[j] = 1'b0;
    for (int t = 0; t < NT; t++) cnt[t] = 0;
    exp_kn = (n < K) ? n : K;
    for (int r = 0; r < exp_kn; r++) begin
      int best = -1;
      for (int j = 0; j < n; j++) begin
        if (!used[j] && (best < 0 || acc_dist[j] < acc_dist[best])) best = j;
      end
      used[best] = 1'b1;
      exp_kd[r] = acc_dist[best];
      exp_kt[r] = acc_type[best];
      cnt[acc_type[best]]++;
    end
    exp_type = 0;
    for (int t = 1; t < NT; t++) if (cnt[t] > cnt[exp_type]) exp_type = t;
  endtask

  task automatic begin_inference();
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    acc_dist.delete();
    acc_type.delete();
  endtask

  // Returns right after the posedge that accepted the final pair.
  task automatic send_stream(input bit set_last, input bit gaps);
    int n;
    n = stim_dist.size();
    for (int i = 0; i < n; i++) begin
      int guard = 0;
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_valid = 1'b0;
        @(negedge clk);
      end
      in_valid = 1'b1;
      in_dist  = stim_dist[i];
      in_type  = stim_type[i];
      in_last  = set_last && (i == n - 1);
      #1;
      while (!in_ready && guard < 50) begin
        @(negedge clk);
        #1;
        guard++;
      end
      if (!in_ready) begin
        checks++;
        $display("FAIL send_stream: in_ready=%b after %0d cycles, required 1", in_ready, guard);
        return;
      end
      @(posedge clk);
      acc_dist.push_back(stim_dist[i]);
      acc_type.push_back(stim_type[i]);
      if (i != n - 1) @(negedge clk);
    end
  endtask

  // Counts posedges from the last accept until done; lat stays -1 on timeout.
  task automatic wait_done(input bit hold, input int start_at, output int lat, output int ready_hi);
    lat = -1;
    ready_hi = 0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (in_ready) ready_hi++;
      if (!hold) in_valid = 1'b0;
      start = (c == start_at);
      if (done) begin
        lat = c;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_dist = '0; in_type = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL reset_ready: got %b, required 0", in_ready); else passed++;
    checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b, required 0", done); else passed++;
    checks++;
    if (inferred_type !== 3'd0) $display("FAIL reset_type: got %0d, required 0", inferred_type);
    else passed++;
  endtask

  task automatic test_majority();
    int lat, rh;
    stim_dist.delete(); stim_type.delete();
    for (int i = 0; i < 128; i++) begin
      stim_dist.push_back((i < 15) ? 32'(10 + i) : 32'(100 + i));
      stim_type.push_back((i < 15) ? 3'd5 : 3'd2);
    end
    begin_inference();
    send_stream(1'b1, 1'b0);
    wait_done(1'b0, -1, lat, rh);
    checks++; if (lat != LAT) $display("FAIL majority_latency: got %0d, required %0d", lat, LAT); else passed++;
    checks++;
    if (inferred_type !== 3'd5) $display("FAIL majority_type: got %0d, required 5", inferred_type);
    else passed++;
    @(negedge clk);
    checks++; if (done !== 1'b0) $display("FAIL majority_pulse: done=%b next cycle, required 0", done); else passed++;
  endtask

  task automatic test_few();
    int lat, rh, nv;
    stim_dist = '{32'd7, 32'd3, 32'd9};
    stim_type = '{3'd6, 3'd2, 3'd6};
    begin_inference();
    send_stream(1'b1, 1'b0);
    wait_done(1'b0, -1, lat, rh);
    checks++; if (lat != LAT) $display("FAIL few_latency: got %0d, required %0d", lat, LAT); else passed++;
    checks++;
    if (inferred_type !== 3'd6) $display("FAIL few_type: got %0d, required 6", inferred_type);
    else passed++;
    nv = 0;
    for (int i = 0; i < K; i++) if (dut.valid_q[i]) nv++;
    checks++; if (nv != 3) $display("FAIL few_valid_entries: got %0d, required 3", nv); else passed++;
  endtask

  task automatic test_ties();
    int lat, rh;
    logic [11:0] want, got;
    stim_dist = '{32'd50, 32'd50, 32'd50, 32'd50};
    stim_type = '{3'd4, 3'd1, 3'd4, 3'd1};
    begin_inference();
    send_stream(1'b1, 1'b0);
    wait_done(1'b0, -1, lat, rh);
    checks++;
    if (inferred_type !== 3'd1) $display("FAIL tie_type: got %0d, required 1", inferred_type);
    else passed++;
    want = {3'd4, 3'd1, 3'd4, 3'd1};
    got  = {dut.type_q[0], dut.type_q[1], dut.type_q[2], dut.type_q[3]};
    checks++; if (got !== want) $display("FAIL tie_order: got %h, required %h", got, want); else passed++;
  endtask

  task automatic test_back_to_back_backpressure();
    int lat, rh;
    stim_dist.delete(); stim_type.delete();
    for (int i = 0; i < 6; i++) begin
      stim_dist.push_back($urandom_range(0, 20));
      stim_type.push_back(3'($urandom_range(0, 7)));
    end
    begin_inference();
    send_stream(1'b1, 1'b1);
    run_model();
    wait_done(1'b1, 18, lat, rh);
    in_valid = 1'b0;
    checks++; if (rh != 0) $display("FAIL bp_ready: in_ready high %0d cycles, required 0", rh); else passed++;
    checks++; if (lat != LAT) $display("FAIL bp_latency: got %0d, required %0d", lat, LAT); else passed++;
    checks++;
    if (inferred_type !== 3'(exp_type)) $display("FAIL bp_type: got %0d, required %0d", inferred_type, exp_type);
    else passed++;
    @(negedge clk);
    checks++; if (busy !== 1'b0) $display("FAIL bp_idle: busy=%b, required 0", busy); else passed++;
  endtask

  task automatic test_restart();
    int lat, rh;
    stim_dist = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    stim_type = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    begin_inference();
    send_stream(1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b1; in_dist = 32'd1; in_type = 3'd3; in_last = 1'b0; start = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) $display("FAIL restart_ready: got %b, required 0", in_ready); else passed++;
    @(negedge clk);
    start = 1'b0;
    acc_dist.delete(); acc_type.delete();
    stim_dist = '{32'd100, 32'd101};
    stim_type = '{3'd7, 3'd7};
    send_stream(1'b1, 1'b0);
    wait_done(1'b0, -1, lat, rh);
    checks++;
    if (inferred_type !== 3'd7) $display("FAIL restart_type: got %0d, required 7", inferred_type);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int nd, nv;
    stim_dist = '{32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    stim_type = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd3};
    begin_inference();
    send_stream(1'b0, 1'b0);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b, required 0", busy); else passed++;
    checks++; if (in_ready !== 1'b0) $display("FAIL rstmid_ready: got %b, required 0", in_ready); else passed++;
    checks++;
    if (inferred_type !== 3'd0) $display("FAIL rstmid_type: got %0d, required 0", inferred_type);
    else passed++;
    nv = 0;
    for (int i = 0; i < K; i++) if (dut.valid_q[i]) nv++;
    checks++; if (nv != 0) $display("FAIL rstmid_list: %0d valid entries, required 0", nv); else passed++;
    nd = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) nd++;
    end
    checks++; if (nd != 0) $display("FAIL rstmid_done: %0d pulses, required 0", nd); else passed++;
  endtask

  task automatic test_eviction();
    int lat, rh;
    stim_dist.delete(); stim_type.delete();
    for (int i = 0; i < 20; i++) begin
      stim_dist.push_back(32'(200 - i));
      stim_type.push_back((i < 5) ? 3'd0 : 3'd3);
    end
    begin_inference();
    send_stream(1'b1, 1'b0);
    wait_done(1'b0, -1, lat, rh);
    for (int i = 0; i < K; i++) begin
      checks++;
      if (dut.valid_q[i] !== 1'b1 || dut.dist_q[i] !== 32'(181 + i))
        $display("FAIL evict_entry%0d: got %0d (valid %b), required %0d", i, dut.dist_q[i],
                 dut.valid_q[i], 181 + i);
      else passed++;
    end
    checks++;
    if (inferred_type !== 3'd3) $display("FAIL evict_type: got %0d, required 3", inferred_type);
    else passed++;
  endtask

  task automatic test_random();
    int lat, rh, bad, n;
    bit full;
    for (int it = 0; it < 7; it++) begin
      full = (it == 6);
      n = full ? L : $urandom_range(1, 40);
      stim_dist.delete(); stim_type.delete();
      for (int i = 0; i < n; i++) begin
        stim_dist.push_back(full ? $urandom : $urandom_range(0, 40));
        stim_type.push_back(3'($urandom_range(0, 7)));
      end
      begin_inference();
      send_stream(!full, 1'b1);
      run_model();
      wait_done(1'b0, -1, lat, rh);
      checks++;
      if (lat != LAT) $display("FAIL rand%0d_latency: got %0d, required %0d", it, lat, LAT);
      else passed++;
      checks++;
      if (inferred_type !== 3'(exp_type))
        $display("FAIL rand%0d_type: got %0d, required %0d", it, inferred_type, exp_type);
      else passed++;
      bad = 0;
      for (int i = 0; i < K; i++) begin
        if (i < exp_kn) begin
          if (dut.valid_q[i] !== 1'b1 || dut.dist_q[i] !== exp_kd[i] || dut.type_q[i] !== exp_kt[i])
            bad++;
        end else if (dut.valid_q[i] !== 1'b0) begin
          bad++;
        end
      end
      checks++;
      if (bad != 0) $display("FAIL rand%0d_list: %0d wrong entries, required 0", it, bad);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_majority();
    test_few();
    test_ties();
    test_back_to_back_backpressure();
    test_restart();
    test_reset_mid();
    test_eviction();
    test_random();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/knn_vote_select.md
Name: knn_vote_select

Overview:
- Downstream stage of the KNN distance engine. Consumes one (distance, training type) pair per training matrix for a single inference.
- Keeps a sorted list of the K smallest distances seen so far.
- At end of stream, majority-votes the types of those K neighbours and produces inferred_type with a one-cycle done pulse. This output drives the top-level inference_done / inferred_type.

Parameters:
K, 15, number of neighbours kept and voted
L, 128, maximum training samples per inference (sizes sample counter)
DIST_W, 32, distance width (unsigned)
TYPE_W, 3, type field width; NTYPES = 2**TYPE_W vote bins

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  single-cycle pulse; opens a new inference
in_valid  in  1  distance/type pair valid
in_ready  out  1  block accepts pair when in_valid && in_ready at posedge
in_dist  in  DIST_W  unsigned distance to a training matrix
in_type  in  TYPE_W  type of that training matrix
in_last  in  1  marks final pair of the inference
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when inferred_type is updated
inferred_type  out  TYPE_W  voted type; holds until the next done

Behaviour:
- Reset: the following are cleared, with state going to IDLE:
  - in_ready=0, busy=0, done=0, inferred_type=0
  - all list entries invalid
  - all vote counters 0
- rst has priority over every other input in any state.
- States: IDLE -> COLLECT -> COUNT -> VOTE -> DONE -> IDLE.
- IDLE:
  - start moves to COLLECT next cycle.
  - Entering COLLECT clears list valid bits and the sample counter.
- COLLECT:
  - in_ready=1.
  - Each accepted pair is inserted into the sorted list in the same cycle, giving one accept per cycle sustained.
  - Insertion is a parallel compare plus shift.
  - The new entry goes after every valid entry with distance <= in_dist. Ties therefore keep arrival order, and an earlier sample ranks nearer.
  - If the list is full and in_dist >= entry[K-1], the pair is dropped.
  - Otherwise entry[K-1] is discarded by the shift.
  - Accepting a pair with in_last=1 moves to COUNT. in_ready is 0 from the next cycle.
  - If the sample counter reaches L without in_last, the L-th accepted pair is treated as last.
  - start while in COLLECT restarts the inference: list cleared, counter 0, state stays COLLECT. A pair presented in that same cycle is not accepted (in_ready=0 that cycle).
- COUNT:
  - Runs exactly K cycles, walking entry 0..K-1.
  - Each valid entry increments counter[type]. Invalid entries are skipped, which covers fewer than K samples.
  - Counters are clog2(K+1) bits wide and are cleared on entry to COUNT.
- VOTE:
  - Runs exactly NTYPES cycles, scanning bins 0..NTYPES-1.
  - Running best is replaced only on a strictly greater count, so a tie selects the lowest type index.
- DONE:
  - Lasts 1 cycle. inferred_type is registered and done=1.
  - Next state is IDLE.
- Latency: done asserts K+NTYPES+1 cycles after the posedge that accepted the last pair. With defaults this is 24 cycles.
- Inputs ignored outside their states:
  - start is ignored in COUNT, VOTE and DONE.
  - in_valid is ignored whenever in_ready=0. No pair is lost silently, because the upstream must hold in_valid until in_ready.
- Distances are compared as unsigned. No saturation.

Test Plan:
1. Majority:
   - Stimulus: start, then 128 pairs. Index i<15 → dist 10+i, type 5. Remaining pairs → dist 100+i, type 2. in_last on the 128th.
   - Response: done 24 cycles after the last accept, inferred_type=5, one done pulse.
2. Fewer than K samples:
   - Stimulus: 3 pairs (dist 7,type 6), (dist 3,type 2), (dist 9,type 6, last).
   - Response: inferred_type=6. Entries 3..14 remain invalid and are not counted.
3. Vote tie and distance tie:
   - Stimulus: 4 pairs, all dist 50, types 4,1,4,1 (last on 4th).
   - Response: inferred_type=1 (lowest index wins the 2-2 tie). List order is types 4,1,4,1.
4. Backpressure and ignored start:
   - Stimulus: hold in_valid=1 through COUNT/VOTE and pulse start during VOTE.
   - Response: in_ready=0 throughout, no extra accepts, state sequence unchanged, done still at cycle 24.
5. Restart and reset mid-collect:
   - Stimulus A: start, 5 pairs of type 3, then start again, then 2 pairs of type 7 (last).
   - Response A: inferred_type=7.
   - Stimulus B: repeat, but assert rst for 1 cycle after the 5th pair.
   - Response B: state IDLE, busy=0, inferred_type=0, no done.
6. Full-list eviction:
   - Stimulus: 20 pairs with decreasing dist 200..181; the 5 farthest are type 0, the rest type 3.
   - Response: the list holds dist 181..195, inferred_type=3.
